// File: rtl/tof_echo_detect_if.sv
// Handshake and data bundle between the sliding-DFT stage, the echo detector and the readout.
// The DFT side and the readout side together form the master; the detector is the slave.
interface tof_echo_detect_if #(
    parameter int TW = 20
);
    logic               start;
    logic               abort;
    logic signed [63:0] cos_sum;
    logic signed [63:0] sin_sum;
    logic        [63:0] threshold;
    logic               busy;
    logic               result_valid;
    logic               timeout;
    logic      [TW-1:0] cross_time;
    logic      [TW-1:0] peak_time;
    logic        [63:0] peak_mag;

    modport master (
        output start, abort, cos_sum, sin_sum, threshold,
        input  busy, result_valid, timeout, cross_time, peak_time, peak_mag
    );

    modport slave (
        input  start, abort, cos_sum, sin_sum, threshold,
        output busy, result_valid, timeout, cross_time, peak_time, peak_mag
    );
endinterface

// File: rtl/tof_echo_detect.sv
// Squared-magnitude pipeline over the DFT sums plus an FSM that times the echo after each burst:
// first threshold crossing, earliest magnitude peak inside a window, or timeout.
module tof_echo_detect #(
    parameter int SHIFT    = 24,
    parameter int TW       = 20,
    parameter int BLANK    = 400,
    parameter int PEAK_WIN = 200,
    parameter int TIMEOUT  = 100000
) (
    input  logic              clk,
    input  logic              rst,
    tof_echo_detect_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_BLANK, S_SEARCH, S_PEAK, S_DONE} state_t;

    localparam logic [TW-1:0]      BLANK_LAST = TW'(BLANK - 1);
    localparam logic [TW-1:0]      TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]      WIN_M1     = TW'(PEAK_WIN - 1);
    localparam logic signed [63:0] SAT_MAX    = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] SAT_MIN    = 64'shFFFF_FFFF_8000_0000;

    state_t        state_reg, state_next;
    logic          start_acc;
    logic [TW-1:0] ts_cnt_reg, in_ts;
    logic          in_vld;
    logic [2:0]    vld_reg;
    logic [TW-1:0] ts1_reg, ts2_reg, ts3_reg;
    logic [63:0]   mag_reg;

    logic [63:0]   thr_reg, thr_next;
    logic [TW-1:0] cross_reg, cross_next;
    logic [TW-1:0] pk_t_reg, pk_t_next;
    logic [63:0]   pk_m_reg, pk_m_next;
    logic          to_next, load_res;

    logic          timeout_reg;
    logic [TW-1:0] cross_out_reg, peak_t_out_reg;
    logic [63:0]   peak_m_out_reg;

    logic signed [63:0] sum_in [2];
    assign sum_in[0] = bus.cos_sum;
    assign sum_in[1] = bus.sin_sum;

    assign start_acc = (state_reg == S_IDLE) && bus.start && !bus.abort;
    assign in_ts     = start_acc ? '0 : ts_cnt_reg;
    assign in_vld    = start_acc || (state_reg != S_IDLE);

    // Per-channel shift, saturate to 32 bits, then square.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_ch
            logic signed [63:0] shifted;
            logic signed [31:0] sat_next;
            logic signed [31:0] sat_reg;
            logic signed [63:0] sat_ext;
            logic        [63:0] sq_reg;

            assign shifted = sum_in[gi] >>> SHIFT;
            assign sat_ext = 64'(sat_reg);

            always_comb begin
                sat_next = shifted[31:0];
                if (shifted > SAT_MAX)
                    sat_next = 32'sh7FFF_FFFF;
                else if (shifted < SAT_MIN)
                    sat_next = 32'sh8000_0000;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sat_reg <= '0;
                    sq_reg  <= '0;
                end else begin
                    sat_reg <= sat_next;
                    sq_reg  <= $unsigned(sat_ext * sat_ext);
                end
            end
        end
    endgenerate

    // Tags ride alongside the data; an accepted start flushes any older tagged samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt_reg <= '0;
            vld_reg    <= '0;
            ts1_reg    <= '0;
            ts2_reg    <= '0;
            ts3_reg    <= '0;
            mag_reg    <= '0;
        end else begin
            ts_cnt_reg <= in_ts + TW'(1);
            vld_reg[0] <= in_vld;
            vld_reg[1] <= vld_reg[0] && !start_acc;
            vld_reg[2] <= vld_reg[1] && !start_acc;
            ts1_reg    <= in_ts;
            ts2_reg    <= ts1_reg;
            ts3_reg    <= ts2_reg;
            mag_reg    <= gen_ch[0].sq_reg + gen_ch[1].sq_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        thr_next   = thr_reg;
        cross_next = cross_reg;
        pk_t_next  = pk_t_reg;
        pk_m_next  = pk_m_reg;
        to_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_acc) begin
                    thr_next   = bus.threshold;
                    state_next = S_BLANK;
                end
            end
            S_BLANK: begin
                if (vld_reg[2] && ts3_reg == BLANK_LAST)
                    state_next = S_SEARCH;
            end
            S_SEARCH: begin
                if (vld_reg[2]) begin
                    if (mag_reg >= thr_reg) begin
                        cross_next = ts3_reg;
                        pk_t_next  = ts3_reg;
                        pk_m_next  = mag_reg;
                        state_next = (PEAK_WIN == 1) ? S_DONE : S_PEAK;
                    end else if (ts3_reg == TO_LAST) begin
                        to_next    = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_PEAK: begin
                if (vld_reg[2]) begin
                    if (mag_reg > pk_m_reg) begin
                        pk_t_next = ts3_reg;
                        pk_m_next = mag_reg;
                    end
                    if (ts3_reg == cross_reg + WIN_M1)
                        state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.abort && state_reg != S_IDLE)
            state_next = S_IDLE;
        load_res = (state_next == S_DONE) && (state_reg != S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            thr_reg        <= '0;
            cross_reg      <= '0;
            pk_t_reg       <= '0;
            pk_m_reg       <= '0;
            timeout_reg    <= 1'b0;
            cross_out_reg  <= '0;
            peak_t_out_reg <= '0;
            peak_m_out_reg <= '0;
        end else begin
            state_reg <= state_next;
            thr_reg   <= thr_next;
            cross_reg <= cross_next;
            pk_t_reg  <= pk_t_next;
            pk_m_reg  <= pk_m_next;
            if (load_res) begin
                timeout_reg    <= to_next;
                cross_out_reg  <= to_next ? '0 : cross_next;
                peak_t_out_reg <= to_next ? '0 : pk_t_next;
                peak_m_out_reg <= to_next ? '0 : pk_m_next;
            end
        end
    end

    assign bus.busy         = (state_reg != S_IDLE);
    assign bus.result_valid = (state_reg == S_DONE);
    assign bus.timeout      = timeout_reg;
    assign bus.cross_time   = cross_out_reg;
    assign bus.peak_time    = peak_t_out_reg;
    assign bus.peak_mag     = peak_m_out_reg;
endmodule

// File: tb/tb_tof_echo_detect.sv
// Directed bench for tof_echo_detect: each task drives one scenario and checks timing and results.
module tb_tof_echo_detect;
    localparam int SHIFT    = 0;
    localparam int TW       = 20;
    localparam int BLANK    = 400;
    localparam int PEAK_WIN = 200;
    localparam int TIMEOUT  = 1000;
    localparam logic [63:0] SAT_MAG = 64'h7FFF_FFFF_0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tof_echo_detect_if #(.TW(TW)) bus ();

    tof_echo_detect #(
        .SHIFT(SHIFT), .TW(TW), .BLANK(BLANK), .PEAK_WIN(PEAK_WIN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int            rv_cyc;
    int            rv_count;
    logic          res_to;
    logic [TW-1:0] res_ct, res_pt;
    logic [63:0]   res_pm;

    // Input waveform per scenario, indexed by timestamp relative to the accepted start.
    function automatic void pat(input int mode, input int ts,
                                output logic signed [63:0] c, output logic signed [63:0] s);
        c = '0;
        s = '0;
        case (mode)
            1: if (ts >= 500 && ts <= 900) c = (ts == 510) ? 64'sd2000 : 64'sd1000;
            2: if (ts >= 100 && ts <= 700) c = 64'sd1000;
            3: if (ts >= 400) begin
                   c = 64'sd1 <<< 40;
                   s = -(64'sd1 <<< 40);
               end
            default: ;
        endcase
    endfunction

    task automatic run(input string name, input int mode, input logic [63:0] thr,
                       input int budget, input int abort_at, input bit extra_starts);
        logic signed [63:0] c, s;
        rv_cyc   = -1;
        rv_count = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            pat(mode, i, c, s);
            bus.cos_sum   = c;
            bus.sin_sum   = s;
            bus.threshold = (i == 0) ? thr : 64'hFFFF_FFFF_FFFF_FFFF;
            bus.start     = (i == 0) || (extra_starts && (i == 10 || i == 700));
            bus.abort     = (i == abort_at);
            if (i == 0) begin
                n_checks++;
                if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0)
                    $display("FAIL %s idle_before_start: busy=%b rv=%b, want 0/0", name, bus.busy, bus.result_valid);
                else n_pass++;
            end
            if (i == 1) begin
                n_checks++;
                if (bus.busy !== 1'b1) $display("FAIL %s busy_rise: busy=%b, want 1", name, bus.busy);
                else n_pass++;
            end
            if (abort_at >= 0 && i == abort_at + 1) begin
                n_checks++;
                if (bus.busy !== 1'b0) $display("FAIL %s busy_after_abort: busy=%b, want 0", name, bus.busy);
                else n_pass++;
            end
            if (bus.result_valid === 1'b1) begin
                rv_count++;
                rv_cyc = i;
                res_to = bus.timeout;
                res_ct = bus.cross_time;
                res_pt = bus.peak_time;
                res_pm = bus.peak_mag;
                break;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        $display("tx %s: rv_cycle=%0d timeout=%b cross=%0d peak_t=%0d peak_mag=%0d",
                 name, rv_cyc, bus.timeout, bus.cross_time, bus.peak_time, bus.peak_mag);
    endtask

    task automatic check_result(input string name, input int exp_cyc, input logic exp_to,
                                input int exp_ct, input int exp_pt, input logic [63:0] exp_pm);
        n_checks++;
        if (rv_cyc !== exp_cyc) $display("FAIL %s rv_cycle: got %0d, want %0d", name, rv_cyc, exp_cyc);
        else n_pass++;
        n_checks++;
        if (res_to !== exp_to) $display("FAIL %s timeout: got %b, want %b", name, res_to, exp_to);
        else n_pass++;
        n_checks++;
        if (res_ct !== TW'(exp_ct)) $display("FAIL %s cross_time: got %0d, want %0d", name, res_ct, exp_ct);
        else n_pass++;
        n_checks++;
        if (res_pt !== TW'(exp_pt)) $display("FAIL %s peak_time: got %0d, want %0d", name, res_pt, exp_pt);
        else n_pass++;
        n_checks++;
        if (res_pm !== exp_pm) $display("FAIL %s peak_mag: got %0d, want %0d", name, res_pm, exp_pm);
        else n_pass++;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.cos_sum = '0; bus.sin_sum = '0; bus.threshold = '0;
        rst = 1'b0;
        #12;
        n_checks++;
        if ({bus.busy, bus.result_valid, bus.timeout} !== 3'b000)
            $display("FAIL reset_flags: busy/rv/to=%b%b%b, want 000", bus.busy, bus.result_valid, bus.timeout);
        else n_pass++;
        n_checks++;
        if (bus.cross_time !== '0 || bus.peak_time !== '0)
            $display("FAIL reset_times: cross=%0d peak_t=%0d, want 0/0", bus.cross_time, bus.peak_time);
        else n_pass++;
        n_checks++;
        if (bus.peak_mag !== '0) $display("FAIL reset_mag: got %0d, want 0", bus.peak_mag);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        $display("tx reset: released");
    endtask

    task automatic test_basic_echo();
        run("basic", 1, 64'd1_000_000, 800, -1, 1'b0);
        check_result("basic", 703, 1'b0, 500, 510, 64'd4_000_000);
    endtask

    task automatic test_blanking();
        run("blanking", 2, 64'd1_000_000, 800, -1, 1'b0);
        check_result("blanking", 603, 1'b0, 400, 400, 64'd1_000_000);
    endtask

    task automatic test_timeout();
        run("timeout", 0, 64'd1_000_000, 1100, -1, 1'b1);
        check_result("timeout", 1003, 1'b1, 0, 0, 64'd0);
    endtask

    task automatic test_saturation();
        run("saturation", 3, 64'd1, 800, -1, 1'b0);
        check_result("saturation", 603, 1'b0, 400, 400, SAT_MAG);
    endtask

    task automatic test_abort();
        run("abort", 1, 64'd1_000_000, 750, 603, 1'b0);
        n_checks++;
        if (rv_cyc !== -1) $display("FAIL abort_no_result: rv_cycle=%0d, want none (-1)", rv_cyc);
        else n_pass++;
        n_checks++;
        if (bus.timeout !== 1'b0 || bus.cross_time !== TW'(400) || bus.peak_time !== TW'(400) || bus.peak_mag !== SAT_MAG)
            $display("FAIL abort_keeps_results: to=%b cross=%0d peak_t=%0d mag=%0d, want 0/400/400/%0d",
                     bus.timeout, bus.cross_time, bus.peak_time, bus.peak_mag, SAT_MAG);
        else n_pass++;
        run("after_abort", 1, 64'd1_000_000, 800, -1, 1'b0);
        check_result("after_abort", 703, 1'b0, 500, 510, 64'd4_000_000);
    endtask

    task automatic test_back_to_back();
        run("b2b_first", 2, 64'd1_000_000, 800, -1, 1'b0);
        check_result("b2b_first", 603, 1'b0, 400, 400, 64'd1_000_000);
        run("b2b_second", 1, 64'd1_000_000, 800, -1, 1'b0);
        check_result("b2b_second", 703, 1'b0, 500, 510, 64'd4_000_000);
    endtask

    task automatic test_async_reset();
        logic signed [63:0] c, s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            pat(2, i, c, s);
            bus.cos_sum   = c;
            bus.sin_sum   = s;
            bus.threshold = 64'd1_000_000;
            bus.start     = (i == 0);
        end
        bus.start = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.result_valid, bus.timeout} !== 3'b000)
            $display("FAIL async_reset_flags: busy/rv/to=%b%b%b, want 000", bus.busy, bus.result_valid, bus.timeout);
        else n_pass++;
        n_checks++;
        if (bus.cross_time !== '0 || bus.peak_time !== '0 || bus.peak_mag !== '0)
            $display("FAIL async_reset_results: cross=%0d peak_t=%0d mag=%0d, want 0/0/0",
                     bus.cross_time, bus.peak_time, bus.peak_mag);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        $display("tx async_reset: applied mid-blank");
        run("after_reset", 1, 64'd1_000_000, 800, -1, 1'b0);
        check_result("after_reset", 703, 1'b0, 500, 510, 64'd4_000_000);
    endtask

    initial begin
        test_reset();
        test_basic_echo();
        test_blanking();
        test_timeout();
        test_saturation();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
